// File: rtl/seg7_pkg.sv
// Shared types, segment encoding and FSM states for the seven-segment scanning display.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t       SEG_DASH  = 7'h01;
   localparam seg_t       SEG_BLANK = 7'h00;
   // Nibble code stored in a display register to request a dash
   localparam logic [3:0] NIB_DASH  = 4'hF;

   typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

   function automatic seg_t digit_to_seg(logic [3:0] d);
      seg_t s;
      case (d)
         4'd0:     s = 7'h7E;
         4'd1:     s = 7'h30;
         4'd2:     s = 7'h6D;
         4'd3:     s = 7'h79;
         4'd4:     s = 7'h33;
         4'd5:     s = 7'h5B;
         4'd6:     s = 7'h5F;
         4'd7:     s = 7'h70;
         4'd8:     s = 7'h7F;
         4'd9:     s = 7'h7B;
         NIB_DASH: s = SEG_DASH;
         default:  s = SEG_BLANK;
      endcase
      return s;
   endfunction

   function automatic longint unsigned pow10(int unsigned n);
      longint unsigned p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/seg7_scan_disp_if.sv
// Load/status/display bundle of the scanning display; the slave side is the display block.
interface seg7_scan_disp_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WIDTH  = 14
);
   import seg7_pkg::*;

   logic [WIDTH-1:0]  bin_in;
   logic              load;
   logic              busy;
   logic              done;
   logic              overflow;
   seg_t              seg;
   logic [DIGITS-1:0] digit_sel;

   modport master (
      output bin_in, load,
      input  busy, done, overflow, seg, digit_sel
   );

   modport slave (
      input  bin_in, load,
      output busy, done, overflow, seg, digit_sel
   );

endinterface

// File: rtl/bcd_dabble.sv
// Serial double-dabble converter: one shift per cycle, then latches DIGITS nibbles (or dashes)
// into the display registers.
module bcd_dabble import seg7_pkg::*; #(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [WIDTH-1:0]       bin_in,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [DIGITS-1:0][3:0] disp
);

   localparam longint unsigned Limit = pow10(DIGITS);
   localparam int unsigned     StepW = $clog2(WIDTH);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       sh_q, sh_d;
   logic [DIGITS*4-1:0]    acc_q, acc_d, acc_adj;
   logic [StepW-1:0]       step_q, step_d;
   logic                   ovp_q, ovp_d, ov_q, ov_d, done_q, done_d;
   logic [DIGITS-1:0][3:0] disp_q, disp_d;
   logic                   last_step;

   assign last_step = (step_q == StepW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (load) state_d = StConv;
         StConv:  if (last_step) state_d = StLatch;
         StLatch: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StConv);
   end

   // Truncating the accumulator to DIGITS nibbles keeps the value modulo 10**DIGITS
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
      sh_d   = sh_q;
      acc_d  = acc_q;
      step_d = step_q;
      ovp_d  = ovp_q;
      ov_d   = ov_q;
      disp_d = disp_q;
      done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               sh_d   = bin_in;
               acc_d  = '0;
               step_d = '0;
               ovp_d  = ({{(64 - WIDTH){1'b0}}, bin_in} >= Limit);
            end
         end
         StConv: begin
            acc_d  = {acc_adj[DIGITS*4-2:0], sh_q[WIDTH-1]};
            sh_d   = sh_q << 1;
            step_d = step_q + 1'b1;
         end
         StLatch: begin
            done_d = 1'b1;
            ov_d   = ovp_q;
            for (int i = 0; i < DIGITS; i++) begin
               disp_d[i] = ovp_q ? NIB_DASH : acc_q[i*4 +: 4];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_q   <= '0;
         acc_q  <= '0;
         step_q <= '0;
         ovp_q  <= 1'b0;
         ov_q   <= 1'b0;
         done_q <= 1'b0;
         disp_q <= '0;
      end else begin
         sh_q   <= sh_d;
         acc_q  <= acc_d;
         step_q <= step_d;
         ovp_q  <= ovp_d;
         ov_q   <= ov_d;
         done_q <= done_d;
         disp_q <= disp_d;
      end
   end

   assign done     = done_q;
   assign overflow = ov_q;
   assign disp     = disp_q;

endmodule

// File: rtl/seg7_scan_disp.sv
// Binary-to-decimal multiplexed seven-segment display driver.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits.
module seg7_scan_disp import seg7_pkg::*; #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned WIDTH    = 14,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic             clk,
   input  logic             reset,
   seg7_scan_disp_if.slave  bus
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PreW = $clog2(SCAN_DIV);

   logic [DIGITS-1:0][3:0] disp;
   logic                   busy, done, overflow;

   bcd_dabble #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk      (clk),
      .reset    (reset),
      .load     (bus.load),
      .bin_in   (bus.bin_in),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .disp     (disp)
   );

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.overflow = overflow;

   logic [PreW-1:0]   presc_q, presc_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [DIGITS-1:0] sel_q, sel_d, blank;
   logic              seen;
   seg_t              seg_q, seg_d;

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PreW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Dash nibbles are nonzero, so they are never treated as leading zeros
   always_comb begin
      seen  = 1'b0;
      blank = '0;
`ifdef SEG7_LZ_BLANK_EN
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (disp[i] != 4'd0) seen = 1'b1;
         blank[i] = ~seen & (i != 0);
      end
`endif
   end

   always_comb begin
      sel_d = DIGITS'(1) << idx_d;
      seg_d = blank[idx_d] ? SEG_BLANK : digit_to_seg(disp[idx_d]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         idx_q   <= '0;
         sel_q   <= DIGITS'(1);
         seg_q   <= digit_to_seg(4'd0);
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.digit_sel = sel_q;
   assign bus.seg       = seg_q;

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Randomised self-checking bench for seg7_scan_disp against an arithmetic display model.
module tb_seg7_scan_disp;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned WIDTH    = 14;
   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned LIMIT    = 10000;
`ifdef SEG7_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif
   localparam logic [6:0] SEG_TAB [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Edges seen since reset released; the scan position follows from this alone
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   seg7_scan_disp_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

   seg7_scan_disp #(
      .DIGITS   (DIGITS),
      .WIDTH    (WIDTH),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [6:0] exp_seg(int unsigned v, int unsigned i);
      int unsigned p = 1;
      for (int unsigned k = 0; k < i; k++) p = p * 10;
      if (v >= LIMIT) return 7'h01;
      if (LZ && i > 0 && v < p) return 7'h00;
      return SEG_TAB[(v / p) % 10];
   endfunction

   function automatic int unsigned cur_idx();
      return (cyc / SCAN_DIV) % DIGITS;
   endfunction

   // Drives one load pulse from an idle, posedge+#1 aligned start and waits for done
   task automatic run_conv(input int unsigned v, output int edges, output int bcyc,
                           output bit got);
      bus.bin_in = WIDTH'(v);
      bus.load   = 1'b1;
      edges = 0;
      bcyc  = 0;
      got   = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(posedge clk); #1;
         bus.load = 1'b0;
         edges++;
         if (bus.busy) bcyc++;
         if (bus.done) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.load   = 1'b0;
      bus.bin_in = '0;
      reset      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags busy=%b done=%b ovf=%b want 0 0 0",
                  bus.busy, bus.done, bus.overflow);
      end
      checks++;
      if (bus.seg !== 7'h7E || bus.digit_sel !== 4'b0001) begin
         errors++;
         $display("FAIL reset_disp seg=%h sel=%b want 7e 0001", bus.seg, bus.digit_sel);
      end
      reset = 1'b0;
   endtask

   task automatic test_scan();
      for (int k = 0; k < 3 * DIGITS * SCAN_DIV; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.digit_sel !== (4'b0001 << cur_idx()) || bus.seg !== exp_seg(0, cur_idx())) begin
            errors++;
            $display("FAIL scan cyc=%0d sel=%b seg=%h want sel=%b seg=%h", cyc, bus.digit_sel,
                     bus.seg, 4'b0001 << cur_idx(), exp_seg(0, cur_idx()));
         end
      end
   endtask

   task automatic test_convert();
      int edges, bcyc;
      bit got;
      run_conv(1234, edges, bcyc, got);
      checks++;
      if (!got || edges - 1 !== int'(WIDTH + 1)) begin
         errors++;
         $display("FAIL latency got=%0b edges=%0d want %0d", got, edges - 1, WIDTH + 1);
      end
      checks++;
      if (bcyc !== int'(WIDTH)) begin
         errors++;
         $display("FAIL busy_len busy=%0d want %0d", bcyc, WIDTH);
      end
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_1234 ovf=%b want 0", bus.overflow);
      end
      repeat (3) @(posedge clk);
      for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.digit_sel !== (4'b0001 << cur_idx()) || bus.seg !== exp_seg(1234, cur_idx())) begin
            errors++;
            $display("FAIL disp_1234 sel=%b seg=%h want sel=%b seg=%h", bus.digit_sel, bus.seg,
                     4'b0001 << cur_idx(), exp_seg(1234, cur_idx()));
         end
      end
   endtask

   task automatic test_overflow();
      int edges, bcyc;
      bit got;
      int unsigned vals [2] = '{10000, 7};
      for (int n = 0; n < 2; n++) begin
         run_conv(vals[n], edges, bcyc, got);
         checks++;
         if (!got || bus.overflow !== (vals[n] >= LIMIT)) begin
            errors++;
            $display("FAIL ovf_flag v=%0d got=%0b ovf=%b want %b", vals[n], got, bus.overflow,
                     vals[n] >= LIMIT);
         end
         repeat (3) @(posedge clk);
         for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.seg !== exp_seg(vals[n], cur_idx())) begin
               errors++;
               $display("FAIL ovf_disp v=%0d idx=%0d seg=%h want %h", vals[n], cur_idx(),
                        bus.seg, exp_seg(vals[n], cur_idx()));
            end
         end
      end
   endtask

   task automatic test_random();
      int edges, bcyc;
      bit got;
      int unsigned v;
      for (int n = 0; n < 10; n++) begin
         case (n)
            0:       v = 0;
            1:       v = 9999;
            2:       v = 16383;
            default: v = $urandom_range(16383, 0);
         endcase
         run_conv(v, edges, bcyc, got);
         checks++;
         if (!got || bus.overflow !== (v >= LIMIT)) begin
            errors++;
            $display("FAIL rand_ovf v=%0d got=%0b ovf=%b", v, got, bus.overflow);
         end
         repeat (3) @(posedge clk);
         for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.digit_sel !== (4'b0001 << cur_idx()) || bus.seg !== exp_seg(v, cur_idx())) begin
               errors++;
               $display("FAIL rand_disp v=%0d sel=%b seg=%h want sel=%b seg=%h", v,
                        bus.digit_sel, bus.seg, 4'b0001 << cur_idx(), exp_seg(v, cur_idx()));
            end
         end
      end
   endtask

   task automatic test_ignore_load();
      int ndone = 0;
      bus.bin_in = WIDTH'(4321);
      bus.load   = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.bin_in = WIDTH'(8765);
      bus.load   = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
      if (bus.done) ndone++;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      checks++;
      if (ndone !== 1) begin
         errors++;
         $display("FAIL ignore_load dones=%0d want 1", ndone);
      end
      for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.seg !== exp_seg(4321, cur_idx())) begin
            errors++;
            $display("FAIL ignore_disp idx=%0d seg=%h want %h", cur_idx(), bus.seg,
                     exp_seg(4321, cur_idx()));
         end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned v2 = $urandom_range(9999, 0);
      bit got = 1'b0;
      bus.bin_in = WIDTH'(5555);
      bus.load   = 1'b1;
      for (int k = 0; k < 100 && !got; k++) begin
         @(posedge clk); #1;
         if (bus.done) got = 1'b1;
      end
      bus.bin_in = WIDTH'(v2);
      @(posedge clk); #1;
      checks++;
      if (!got || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart got=%0b done=%b busy=%b want 1 0 1", got, bus.done, bus.busy);
      end
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(posedge clk); #1;
         if (bus.done) got = 1'b1;
      end
      bus.load = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL b2b_done2 got=0 want 1");
      end
      repeat (3) @(posedge clk);
      for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.seg !== exp_seg(v2, cur_idx())) begin
            errors++;
            $display("FAIL b2b_disp v=%0d idx=%0d seg=%h want %h", v2, cur_idx(), bus.seg,
                     exp_seg(v2, cur_idx()));
         end
      end
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      bus.bin_in = WIDTH'(4321);
      bus.load   = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL abort_flags busy=%b done=%b ovf=%b want 0 0 0",
                  bus.busy, bus.done, bus.overflow);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         errors++;
         $display("FAIL abort_done dones=%0d want 0", ndone);
      end
      for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.digit_sel !== (4'b0001 << cur_idx()) || bus.seg !== exp_seg(0, cur_idx())) begin
            errors++;
            $display("FAIL abort_disp sel=%b seg=%h want sel=%b seg=%h", bus.digit_sel, bus.seg,
                     4'b0001 << cur_idx(), exp_seg(0, cur_idx()));
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_convert();
      test_overflow();
      test_random();
      test_ignore_load();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
